// File: rtl/ofs_plat_avalon_mem_arb_pkg.sv
// Shared types and helpers for the split read/write Avalon arbiter.
//   t_rdwr_grant  : which source channel owns the shared sink this cycle.
//   run_cnt_width : width of the fairness run counter for a given pair of
//                   maximum run lengths.
package ofs_plat_avalon_mem_arb_pkg;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_RD   = 2'd1,
    GRANT_WR   = 2'd2
  } t_rdwr_grant;

  // log2 of the larger run limit plus one bit, so MAX_RUN-1 always fits.
  function automatic int run_cnt_width(input int rd_max_run, input int wr_max_run);
    int m;
    m = (rd_max_run > wr_max_run) ? rd_max_run : wr_max_run;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/ofs_plat_avalon_wr_burst_tracker.sv
// Tracks write bursts on an Avalon write channel.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   beat_accepted  : one write beat was accepted this cycle
//   burstcount     : burstcount presented with the beat (used on first beat)
//   wr_locked      : a multi-beat burst is in progress
//   sop            : the next accepted beat is the first beat of a burst
//   beats_left     : beats still owed by the burst in progress
module ofs_plat_avalon_wr_burst_tracker #(
  parameter int BURST_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               beat_accepted,
  input  logic [BURST_W-1:0] burstcount,
  output logic               wr_locked,
  output logic               sop,
  output logic [BURST_W-1:0] beats_left
);

  logic               wr_locked_q, wr_locked_d;
  logic [BURST_W-1:0] beats_left_q, beats_left_d;

  always_comb begin
    wr_locked_d  = wr_locked_q;
    beats_left_d = beats_left_q;
    if (beat_accepted) begin
      if (!wr_locked_q) begin
        // Single-beat bursts never lock.
        if (burstcount > BURST_W'(1)) begin
          wr_locked_d  = 1'b1;
          beats_left_d = burstcount - BURST_W'(1);
        end
      end else begin
        beats_left_d = beats_left_q - BURST_W'(1);
        if (beats_left_q == BURST_W'(1)) begin
          wr_locked_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_locked_q  <= 1'b0;
      beats_left_q <= '0;
    end else begin
      wr_locked_q  <= wr_locked_d;
      beats_left_q <= beats_left_d;
    end
  end

  assign wr_locked  = wr_locked_q;
  assign sop        = !wr_locked_q;
  assign beats_left = beats_left_q;

endmodule

// File: rtl/ofs_plat_avalon_mem_rdwr_if_arb_to_mem_if.sv
// Arbitrates a split read/write Avalon source onto one shared Avalon sink.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   src_rd_*          : source read command channel and read responses
//   src_wr_*          : source write command channel and write responses
//   snk_*             : shared sink command channel and its responses
//   dbg_*             : grant and arbitration state for observation
// Handshake: a command transfers in a cycle where its read/write strobe is
// high and the matching waitrequest is low. Grant is combinational from
// registered state and the source strobes only, so a stalled sink never
// moves the grant. Responses pass straight through.
module ofs_plat_avalon_mem_rdwr_if_arb_to_mem_if
  import ofs_plat_avalon_mem_arb_pkg::*;
#(
  parameter int RD_MAX_RUN = 4,
  parameter int WR_MAX_RUN = 4,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int BURST_W    = 4,
  parameter int USER_W     = 4,
  localparam int BE_W      = DATA_W / 8,
  localparam int RUN_W     = run_cnt_width(RD_MAX_RUN, WR_MAX_RUN)
) (
  input  logic               clk,
  input  logic               reset,
  // source read channel
  input  logic [ADDR_W-1:0]  src_rd_address,
  input  logic               src_rd_read,
  input  logic [BURST_W-1:0] src_rd_burstcount,
  input  logic [BE_W-1:0]    src_rd_byteenable,
  input  logic [USER_W-1:0]  src_rd_user,
  output logic               src_rd_waitrequest,
  output logic               src_rd_readdatavalid,
  output logic [DATA_W-1:0]  src_rd_readdata,
  output logic [1:0]         src_rd_response,
  output logic [USER_W-1:0]  src_rd_readresponseuser,
  // source write channel
  input  logic [ADDR_W-1:0]  src_wr_address,
  input  logic               src_wr_write,
  input  logic [BURST_W-1:0] src_wr_burstcount,
  input  logic [BE_W-1:0]    src_wr_byteenable,
  input  logic [DATA_W-1:0]  src_wr_writedata,
  input  logic [USER_W-1:0]  src_wr_user,
  output logic               src_wr_waitrequest,
  output logic               src_wr_writeresponsevalid,
  output logic [1:0]         src_wr_writeresponse,
  output logic [USER_W-1:0]  src_wr_writeresponseuser,
  // shared sink
  output logic [ADDR_W-1:0]  snk_address,
  output logic               snk_read,
  output logic               snk_write,
  output logic [BURST_W-1:0] snk_burstcount,
  output logic [BE_W-1:0]    snk_byteenable,
  output logic [DATA_W-1:0]  snk_writedata,
  output logic [USER_W-1:0]  snk_user,
  input  logic               snk_waitrequest,
  input  logic               snk_readdatavalid,
  input  logic [DATA_W-1:0]  snk_readdata,
  input  logic [1:0]         snk_response,
  input  logic [USER_W-1:0]  snk_readresponseuser,
  input  logic               snk_writeresponsevalid,
  input  logic [1:0]         snk_writeresponse,
  input  logic [USER_W-1:0]  snk_writeresponseuser,
  // observation
  output logic [1:0]         dbg_grant,
  output logic               dbg_wr_locked,
  output logic [BURST_W-1:0] dbg_wr_beats_left,
  output logic               dbg_pri_wr,
  output logic [RUN_W-1:0]   dbg_run_cnt
);

  localparam logic [RUN_W-1:0] RD_LAST = RUN_W'(RD_MAX_RUN - 1);
  localparam logic [RUN_W-1:0] WR_LAST = RUN_W'(WR_MAX_RUN - 1);

  t_rdwr_grant        grant;
  logic               grant_rd, grant_wr;
  logic               wr_locked, wr_sop;
  logic [BURST_W-1:0] wr_beats_left;
  logic               rd_accepted, wr_accepted, wr_first_accepted;
  logic               pri_wr_q, pri_wr_d;
  logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
  logic               ev_wr, other_req;

  always_comb begin
    grant = GRANT_NONE;
    if (wr_locked) begin
      grant = GRANT_WR;
    end else if (src_rd_read && src_wr_write) begin
      grant = pri_wr_q ? GRANT_WR : GRANT_RD;
    end else if (src_rd_read) begin
      grant = GRANT_RD;
    end else if (src_wr_write) begin
      grant = GRANT_WR;
    end
  end

  assign grant_rd = (grant == GRANT_RD);
  assign grant_wr = (grant == GRANT_WR);

  // Reset forces the command path idle; responses are left alone.
  assign snk_read           = !reset && src_rd_read && grant_rd;
  assign snk_write          = !reset && src_wr_write && grant_wr;
  assign src_rd_waitrequest = reset || snk_waitrequest || !grant_rd;
  assign src_wr_waitrequest = reset || snk_waitrequest || !grant_wr;

  always_comb begin
    if (grant_rd) begin
      snk_address    = src_rd_address;
      snk_burstcount = src_rd_burstcount;
      snk_byteenable = src_rd_byteenable;
      snk_user       = src_rd_user;
    end else begin
      snk_address    = src_wr_address;
      snk_burstcount = src_wr_burstcount;
      snk_byteenable = src_wr_byteenable;
      snk_user       = src_wr_user;
    end
  end

  assign snk_writedata = src_wr_writedata;

  assign src_rd_readdatavalid      = snk_readdatavalid;
  assign src_rd_readdata           = snk_readdata;
  assign src_rd_response           = snk_response;
  assign src_rd_readresponseuser   = snk_readresponseuser;
  assign src_wr_writeresponsevalid = snk_writeresponsevalid;
  assign src_wr_writeresponse      = snk_writeresponse;
  assign src_wr_writeresponseuser  = snk_writeresponseuser;

  assign rd_accepted       = snk_read && !snk_waitrequest;
  assign wr_accepted       = snk_write && !snk_waitrequest;
  assign wr_first_accepted = wr_accepted && wr_sop;

  ofs_plat_avalon_wr_burst_tracker #(
    .BURST_W (BURST_W)
  ) u_wr_burst (
    .clk           (clk),
    .reset         (reset),
    .beat_accepted (wr_accepted),
    .burstcount    (src_wr_burstcount),
    .wr_locked     (wr_locked),
    .sop           (wr_sop),
    .beats_left    (wr_beats_left)
  );

  // Fairness: only reads and first write beats are run events. A run only
  // grows while the other side is waiting; otherwise it restarts.
  always_comb begin
    pri_wr_d  = pri_wr_q;
    run_cnt_d = run_cnt_q;
    ev_wr     = wr_first_accepted;
    other_req = wr_first_accepted ? src_rd_read : src_wr_write;
    if (rd_accepted || wr_first_accepted) begin
      if (!other_req || (ev_wr != pri_wr_q)) begin
        run_cnt_d = '0;
      end else if (run_cnt_q == (ev_wr ? WR_LAST : RD_LAST)) begin
        pri_wr_d  = !pri_wr_q;
        run_cnt_d = '0;
      end else begin
        run_cnt_d = run_cnt_q + RUN_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pri_wr_q  <= 1'b0;
      run_cnt_q <= '0;
    end else begin
      pri_wr_q  <= pri_wr_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_first_accepted) begin
      assert (src_wr_burstcount != '0)
        else $error("illegal write burstcount 0");
    end
  end

  assign dbg_grant         = grant;
  assign dbg_wr_locked     = wr_locked;
  assign dbg_wr_beats_left = wr_beats_left;
  assign dbg_pri_wr        = pri_wr_q;
  assign dbg_run_cnt       = run_cnt_q;

endmodule

// File: tb/tb_ofs_plat_avalon_mem_rdwr_if_arb_to_mem_if.sv
module tb_ofs_plat_avalon_mem_rdwr_if_arb_to_mem_if;

  localparam int RD_RUN = 4;
  localparam int WR_RUN = 2;
  localparam int CMD_W  = 61;

  typedef struct packed {
    logic [15:0] addr;
    logic [3:0]  bc;
    logic [3:0]  user;
    logic [3:0]  be;
    logic [31:0] data;
  } cmd_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] src_rd_address = '0, src_wr_address = '0;
  logic        src_rd_read = 1'b0, src_wr_write = 1'b0;
  logic [3:0]  src_rd_burstcount = 4'd1, src_wr_burstcount = 4'd1;
  logic [3:0]  src_rd_byteenable = '0, src_wr_byteenable = '0;
  logic [3:0]  src_rd_user = '0, src_wr_user = '0;
  logic [31:0] src_wr_writedata = '0;
  logic        src_rd_waitrequest, src_wr_waitrequest;
  logic        src_rd_readdatavalid, src_wr_writeresponsevalid;
  logic [31:0] src_rd_readdata;
  logic [1:0]  src_rd_response, src_wr_writeresponse;
  logic [3:0]  src_rd_readresponseuser, src_wr_writeresponseuser;
  logic [15:0] snk_address;
  logic        snk_read, snk_write;
  logic [3:0]  snk_burstcount, snk_byteenable, snk_user;
  logic [31:0] snk_writedata;
  logic        snk_waitrequest = 1'b0;
  logic        snk_readdatavalid = 1'b0, snk_writeresponsevalid = 1'b0;
  logic [31:0] snk_readdata = '0;
  logic [1:0]  snk_response = '0, snk_writeresponse = '0;
  logic [3:0]  snk_readresponseuser = '0, snk_writeresponseuser = '0;
  logic [1:0]  dbg_grant;
  logic        dbg_wr_locked, dbg_pri_wr;
  logic [3:0]  dbg_wr_beats_left;
  logic [2:0]  dbg_run_cnt;

  ofs_plat_avalon_mem_rdwr_if_arb_to_mem_if #(
    .RD_MAX_RUN (RD_RUN), .WR_MAX_RUN (WR_RUN),
    .ADDR_W (16), .DATA_W (32), .BURST_W (4), .USER_W (4)
  ) dut (
    .clk (clk), .reset (reset),
    .src_rd_address (src_rd_address), .src_rd_read (src_rd_read),
    .src_rd_burstcount (src_rd_burstcount), .src_rd_byteenable (src_rd_byteenable),
    .src_rd_user (src_rd_user), .src_rd_waitrequest (src_rd_waitrequest),
    .src_rd_readdatavalid (src_rd_readdatavalid), .src_rd_readdata (src_rd_readdata),
    .src_rd_response (src_rd_response), .src_rd_readresponseuser (src_rd_readresponseuser),
    .src_wr_address (src_wr_address), .src_wr_write (src_wr_write),
    .src_wr_burstcount (src_wr_burstcount), .src_wr_byteenable (src_wr_byteenable),
    .src_wr_writedata (src_wr_writedata), .src_wr_user (src_wr_user),
    .src_wr_waitrequest (src_wr_waitrequest),
    .src_wr_writeresponsevalid (src_wr_writeresponsevalid),
    .src_wr_writeresponse (src_wr_writeresponse),
    .src_wr_writeresponseuser (src_wr_writeresponseuser),
    .snk_address (snk_address), .snk_read (snk_read), .snk_write (snk_write),
    .snk_burstcount (snk_burstcount), .snk_byteenable (snk_byteenable),
    .snk_writedata (snk_writedata), .snk_user (snk_user),
    .snk_waitrequest (snk_waitrequest), .snk_readdatavalid (snk_readdatavalid),
    .snk_readdata (snk_readdata), .snk_response (snk_response),
    .snk_readresponseuser (snk_readresponseuser),
    .snk_writeresponsevalid (snk_writeresponsevalid),
    .snk_writeresponse (snk_writeresponse),
    .snk_writeresponseuser (snk_writeresponseuser),
    .dbg_grant (dbg_grant), .dbg_wr_locked (dbg_wr_locked),
    .dbg_wr_beats_left (dbg_wr_beats_left), .dbg_pri_wr (dbg_pri_wr),
    .dbg_run_cnt (dbg_run_cnt)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- source / sink driver state ----------------
  cmd_t rd_q[$];
  cmd_t wr_q[$];
  int   wr_beat = 0;
  bit   rd_active = 0, wr_active = 0;
  bit   rd_acc_obs = 0, wr_acc_obs = 0;
  bit   rst_req = 1;
  int   rd_prob = 100, wr_prob = 100, wait_prob = 0;
  int   wait_mode = 0;   // 0: never stall, 1: always stall, 2: random
  bit   resp_both = 0;

  // ---------------- reference model + scoreboard ----------------
  int   m_left = 0;      // beats still owed by the current write burst
  bit   m_pri_wr = 0;
  int   m_run = 0;
  logic [CMD_W-1:0] exp_q[$];
  bit   hist[$];         // 1 = write command seen on sink
  int   n_snk_rd = 0, n_snk_wr = 0, n_rd_blocked = 0;

  task automatic push_rd(input logic [15:0] a, input logic [3:0] bc, input logic [3:0] u);
    cmd_t c;
    c.addr = a; c.bc = bc; c.user = u; c.be = 4'($urandom_range(15)); c.data = '0;
    rd_q.push_back(c);
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [3:0] bc, input logic [3:0] u);
    cmd_t c;
    c.addr = a; c.bc = bc; c.user = u; c.be = 4'($urandom_range(15)); c.data = $urandom;
    wr_q.push_back(c);
  endtask

  task automatic drive();
    if (rd_acc_obs) begin
      void'(rd_q.pop_front());
      rd_active = 0;
    end
    if (wr_acc_obs) begin
      wr_beat++;
      wr_active = 0;
      if (wr_beat == int'(wr_q[0].bc)) begin
        void'(wr_q.pop_front());
        wr_beat = 0;
      end
    end
    reset = rst_req;
    if (rst_req) begin
      rd_active = 0;
      wr_active = 0;
      if (wr_beat != 0) begin
        void'(wr_q.pop_front());   // burst abandoned by reset
        wr_beat = 0;
      end
    end else begin
      if (!rd_active && rd_q.size() > 0 && $urandom_range(99) < rd_prob) rd_active = 1;
      if (!wr_active && wr_q.size() > 0 && $urandom_range(99) < wr_prob) wr_active = 1;
    end
    src_rd_read  = rd_active;
    src_wr_write = wr_active;
    if (rd_q.size() > 0) begin
      src_rd_address = rd_q[0].addr; src_rd_burstcount = rd_q[0].bc;
      src_rd_user = rd_q[0].user; src_rd_byteenable = rd_q[0].be;
    end
    if (wr_q.size() > 0) begin
      src_wr_address = wr_q[0].addr; src_wr_burstcount = wr_q[0].bc;
      src_wr_user = wr_q[0].user; src_wr_byteenable = wr_q[0].be;
      src_wr_writedata = wr_q[0].data + 32'(wr_beat);
    end
    case (wait_mode)
      0:       snk_waitrequest = 1'b0;
      1:       snk_waitrequest = 1'b1;
      default: snk_waitrequest = ($urandom_range(99) < wait_prob);
    endcase
    snk_readdatavalid      = resp_both ? 1'b1 : 1'($urandom_range(1));
    snk_writeresponsevalid = resp_both ? 1'b1 : 1'($urandom_range(1));
    snk_readdata           = $urandom;
    snk_response           = 2'($urandom_range(3));
    snk_readresponseuser   = 4'($urandom_range(15));
    snk_writeresponse      = 2'($urandom_range(3));
    snk_writeresponseuser  = 4'($urandom_range(15));
  endtask

  task automatic fair_event(input bit cls_wr, input bit other_req);
    int limit;
    limit = cls_wr ? WR_RUN : RD_RUN;
    if (!other_req || cls_wr != m_pri_wr) begin
      m_run = 0;
    end else if (m_run + 1 >= limit) begin
      m_pri_wr = !m_pri_wr;
      m_run = 0;
    end else begin
      m_run = m_run + 1;
    end
  endtask

  task automatic check_cycle();
    bit rd, wr, gr, gw, e_rd, e_wr, o_rd, o_wr;
    logic [CMD_W-1:0] obs, exp;
    rd = src_rd_read;
    wr = src_wr_write;
    check_eq("rd_resp", {src_rd_readdatavalid, src_rd_readdata, src_rd_response, src_rd_readresponseuser},
             {snk_readdatavalid, snk_readdata, snk_response, snk_readresponseuser});
    check_eq("wr_resp", {src_wr_writeresponsevalid, src_wr_writeresponse, src_wr_writeresponseuser},
             {snk_writeresponsevalid, snk_writeresponse, snk_writeresponseuser});
    check_eq("dbg_locked", dbg_wr_locked, m_left > 0);
    check_eq("dbg_beats_left", dbg_wr_beats_left, m_left);
    check_eq("dbg_pri_wr", dbg_pri_wr, m_pri_wr);
    check_eq("dbg_run_cnt", dbg_run_cnt, m_run);
    if (reset)             begin gr = 0; gw = 0; end
    else if (m_left > 0)   begin gr = 0; gw = 1; end
    else if (rd && wr)     begin gr = !m_pri_wr; gw = m_pri_wr; end
    else                   begin gr = rd; gw = wr; end
    e_rd = rd && gr;
    e_wr = wr && gw;
    check_eq("snk_read", snk_read, e_rd);
    check_eq("snk_write", snk_write, e_wr);
    check_eq("rd_waitreq", src_rd_waitrequest, reset || snk_waitrequest || !gr);
    check_eq("wr_waitreq", src_wr_waitrequest, reset || snk_waitrequest || !gw);

    if (e_rd && !snk_waitrequest)
      exp_q.push_back({1'b0, src_rd_address, src_rd_burstcount, src_rd_user, src_rd_byteenable, 32'h0});
    if (e_wr && !snk_waitrequest)
      exp_q.push_back({1'b1, src_wr_address, src_wr_burstcount, src_wr_user, src_wr_byteenable, src_wr_writedata});

    // sink monitor
    o_rd = snk_read && !snk_waitrequest;
    o_wr = snk_write && !snk_waitrequest;
    if (o_rd || o_wr) begin
      obs = {o_wr, snk_address, snk_burstcount, snk_user, snk_byteenable, o_wr ? snk_writedata : 32'h0};
      if (exp_q.size() == 0) begin
        check_eq("sb_extra_cmd", 1, 0);
      end else begin
        exp = exp_q.pop_front();
        check_eq("sb_cmd", obs, exp);
      end
      hist.push_back(o_wr);
      if (o_rd) n_snk_rd++;
      if (o_wr) n_snk_wr++;
    end
    if (src_rd_read && src_rd_waitrequest) n_rd_blocked++;
    rd_acc_obs = src_rd_read && !src_rd_waitrequest;
    wr_acc_obs = src_wr_write && !src_wr_waitrequest;

    // model state advance for the coming edge
    if (reset) begin
      m_left = 0; m_pri_wr = 0; m_run = 0;
    end else begin
      if (e_rd && !snk_waitrequest) fair_event(0, wr);
      if (e_wr && !snk_waitrequest) begin
        if (m_left == 0) begin
          m_left = int'(src_wr_burstcount) - 1;
          fair_event(1, rd);
        end else begin
          m_left = m_left - 1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic drain();
    int n;
    rd_prob = 100; wr_prob = 100; wait_mode = 0;
    n = 0;
    while ((rd_q.size() > 0 || wr_q.size() > 0) && n < 200) begin
      step();
      n++;
    end
    check_eq("drain_left", rd_q.size() + wr_q.size(), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_req = 1;
    repeat (3) step();
    rst_req = 0;

    // reads only
    n_snk_rd = 0; n_rd_blocked = 0;
    for (int i = 0; i < 8; i++) push_rd(16'h100 + 16'(i * 4), 4'd2, 4'(i));
    repeat (8) step();
    check_eq("rdonly_count", n_snk_rd, 8);
    check_eq("rdonly_blocked", n_rd_blocked, 0);
    drain();

    // write lock with read arriving at beat 2
    hist.delete(); n_rd_blocked = 0;
    push_wr(16'h200, 4'd4, 4'h3);
    step();
    push_rd(16'h300, 4'd1, 4'h5);
    repeat (4) step();
    check_eq("lock_rd_blocked", n_rd_blocked, 3);
    for (int i = 0; i < 5; i++) begin
      if (i < hist.size()) check_eq("lock_order", hist[i], (i < 4) ? 1 : 0);
      else check_eq("lock_short", hist.size(), 5);
    end
    drain();

    // fairness with both channels saturated
    rst_req = 1; step(); rst_req = 0;
    hist.delete();
    for (int i = 0; i < 12; i++) begin
      push_rd(16'h400 + 16'(i), 4'd1, 4'(i));
      push_wr(16'h800 + 16'(i), 4'd1, 4'(i));
    end
    repeat (18) step();
    for (int i = 0; i < 18; i++) begin
      if (i < hist.size()) check_eq("fair_pattern", hist[i], (i % (RD_RUN + WR_RUN)) >= RD_RUN);
      else check_eq("fair_short", hist.size(), 18);
    end
    drain();

    // sink backpressure mid burst
    n_snk_wr = 0;
    push_wr(16'h500, 4'd3, 4'h7);
    step();
    wait_mode = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("bp_locked", dbg_wr_locked, 1);
    end
    wait_mode = 0;
    repeat (2) step();
    check_eq("bp_beats", n_snk_wr, 3);
    step();
    check_eq("bp_unlocked", dbg_wr_locked, 0);
    drain();

    // simultaneous responses
    resp_both = 1;
    repeat (3) step();
    resp_both = 0;

    // reset mid burst
    push_wr(16'h600, 4'd4, 4'h1);
    step();
    rst_req = 1; step(); rst_req = 0;
    push_rd(16'h700, 4'd1, 4'h2);
    step();
    check_eq("rst_locked", dbg_wr_locked, 0);
    check_eq("rst_pri_wr", dbg_pri_wr, 0);
    check_eq("rst_rd_grant", snk_read && !src_rd_waitrequest, 1);
    drain();

    // randomized traffic
    wait_mode = 2;
    for (int seg = 0; seg < 5; seg++) begin
      rd_prob = $urandom_range(100, 20);
      wr_prob = $urandom_range(100, 20);
      wait_prob = $urandom_range(40);
      for (int c = 0; c < 100; c++) begin
        if (rd_q.size() < 3 && $urandom_range(99) < 40)
          push_rd(16'($urandom), 4'($urandom_range(8, 1)), 4'($urandom_range(15)));
        if (wr_q.size() < 2 && $urandom_range(99) < 30)
          push_wr(16'($urandom), 4'($urandom_range(6, 1)), 4'($urandom_range(15)));
        step();
      end
    end
    drain();
    repeat (2) step();
    check_eq("sb_leftover", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
